// File: rtl/adder_sync.sv
// Datapath adder for the MR ALU. It produces the wrap-around sum and the C/V/Z/N flags
// combinationally, and keeps a one-stage registered copy for the control unit to sample.
module adder_sync #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_valid,
  output logic [N-1:0] out,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_z,
  output logic         flag_n,
  output logic [N-1:0] out_q,
  output logic [3:0]   flags_q,
  output logic         valid_q
);

  // Signed overflow: both operands have the same sign and the result sign differs from it.
  function automatic logic ovf_f(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  logic [N:0]   sum_p0;
  logic [N-1:0] out_d;
  logic [3:0]   flags_d;
  logic         valid_d;

  // Stage p0: combinational sum and flags, independent of clk and rst
  assign sum_p0 = {1'b0, in_a} + {1'b0, in_b};
  assign out    = sum_p0[N-1:0];
  assign flag_c = sum_p0[N];
  assign flag_v = ovf_f(in_a[N-1], in_b[N-1], sum_p0[N-1]);
  assign flag_z = (sum_p0[N-1:0] == '0);
  assign flag_n = sum_p0[N-1];

  always_comb begin
    out_d   = out_q;
    flags_d = flags_q;
    valid_d = 1'b0;
    if (in_valid) begin
      out_d   = out;
      flags_d = {flag_c, flag_v, flag_z, flag_n};
      valid_d = 1'b1;
    end
  end

  // Stage p1: registered copy; reset takes priority over a capture
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      flags_q <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_adder_sync.sv
// Directed checks of the adder_sync combinational sum/flags and registered stage,
// with a short reference-model sweep at N=8 and N=16.
module tb_adder_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        v8 = 1'b0;
  logic [7:0]  out8, outq8;
  logic        c8, ov8, z8, n8, vq8;
  logic [3:0]  fq8;
  logic [15:0] a16 = '0, b16 = '0;
  logic        v16 = 1'b0;
  logic [15:0] out16, outq16;
  logic        c16, ov16, z16, n16, vq16;
  logic [3:0]  fq16;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  adder_sync #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_a(a8), .in_b(b8), .in_valid(v8),
    .out(out8), .flag_c(c8), .flag_v(ov8), .flag_z(z8), .flag_n(n8),
    .out_q(outq8), .flags_q(fq8), .valid_q(vq8)
  );

  adder_sync #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_a(a16), .in_b(b16), .in_valid(v16),
    .out(out16), .flag_c(c16), .flag_v(ov16), .flag_z(z16), .flag_n(n16),
    .out_q(outq16), .flags_q(fq16), .valid_q(vq16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference built from integer arithmetic: returns {C,V,Z,N,sum} with the sum in the low 16 bits.
  function automatic logic [19:0] ref_f(input int w, input int a, input int b);
    int mask, s, sa, sb, ss, r;
    logic c, v, z, n;
    mask = (1 << w) - 1;
    s  = a + b;
    r  = s & mask;
    c  = (s > mask);
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    ss = sa + sb;
    v  = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
    z  = (r == 0);
    n  = (r >= (1 << (w - 1)));
    return {c, v, z, n, r[15:0]};
  endfunction

  task automatic comb8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eo, input logic [3:0] ef);
    a8 = a; b8 = b;
    #1;
    check({tag, ".out"}, {24'd0, out8}, {24'd0, eo});
    check({tag, ".cvzn"}, {28'd0, c8, ov8, z8, n8}, {28'd0, ef});
  endtask

  initial begin
    // Directed combinational vectors, flags given as {C,V,Z,N}
    comb8("5+1",     8'd5,   8'd1,   8'h06, 4'b0000);
    comb8("9+100",   8'd9,   8'd100, 8'h6D, 4'b0000);
    comb8("m1+9",    8'hFF,  8'd9,   8'h08, 4'b1000);
    comb8("255+2",   8'd255, 8'd2,   8'h01, 4'b1000);
    comb8("7F+1",    8'h7F,  8'h01,  8'h80, 4'b0101);
    comb8("80+80",   8'h80,  8'h80,  8'h00, 4'b1110);
    comb8("F0+F0",   8'hF0,  8'hF0,  8'hE0, 4'b1001);
    a16 = 16'hFFFF; b16 = 16'h0001; #1;
    check("w16.ffff+1", {12'd0, c16, ov16, z16, n16, out16}, {12'd0, 4'b1010, 16'h0000});
    a16 = 16'h7FFF; b16 = 16'h0001; #1;
    check("w16.7fff+1", {12'd0, c16, ov16, z16, n16, out16}, {12'd0, 4'b0101, 16'h8000});

    // Registered stage: reset, capture, hold, reset-beats-capture
    @(negedge clk); rst = 1'b1; v8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_q",   {24'd0, outq8}, 32'd0);
    check("rst.flags_q", {28'd0, fq8},   32'd0);
    check("rst.valid_q", {31'd0, vq8},   32'd0);
    check("rst.w16",     {11'd0, vq16, fq16, outq16}, 32'd0);
    @(negedge clk); rst = 1'b0; v8 = 1'b1; a8 = 8'd5; b8 = 8'd1;
    @(posedge clk); #1;
    check("cap.out_q",   {24'd0, outq8}, 32'd6);
    check("cap.flags_q", {28'd0, fq8},   32'd0);
    check("cap.valid_q", {31'd0, vq8},   32'd1);
    @(negedge clk); a8 = 8'h80; b8 = 8'h80;
    @(posedge clk); #1;
    check("cap2.out_q",   {24'd0, outq8}, 32'd0);
    check("cap2.flags_q", {28'd0, fq8},   32'hE);
    @(negedge clk); a8 = 8'd5; b8 = 8'd1;
    @(posedge clk); #1;
    @(negedge clk); v8 = 1'b0; a8 = 8'h7F; b8 = 8'h01;
    @(posedge clk); #1;
    check("hold.out_q",   {24'd0, outq8}, 32'd6);
    check("hold.flags_q", {28'd0, fq8},   32'd0);
    check("hold.valid_q", {31'd0, vq8},   32'd0);
    @(negedge clk); v8 = 1'b1; a8 = 8'h10; b8 = 8'h22;
    @(posedge clk); #1;
    check("cap3.out_q", {24'd0, outq8}, 32'h32);
    @(negedge clk); rst = 1'b1; v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01;
    @(posedge clk); #1;
    check("rstv.out_q",   {24'd0, outq8}, 32'd0);
    check("rstv.flags_q", {28'd0, fq8},   32'd0);
    check("rstv.valid_q", {31'd0, vq8},   32'd0);
    check("rstv.comb",    {20'd0, c8, ov8, z8, n8, out8}, {20'd0, 4'b0101, 8'h80});
    @(negedge clk); rst = 1'b0; v8 = 1'b0;

    // Reference-model sweep at both widths
    for (int i = 0; i < 24; i++) begin
      int ra, rb;
      logic [19:0] e;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      a8 = ra[7:0]; b8 = rb[7:0]; #1;
      e = ref_f(8, ra, rb);
      check("rnd8", {12'd0, c8, ov8, z8, n8, 8'd0, out8}, {12'd0, e});
      ra = int'($urandom_range(0, 65535));
      rb = int'($urandom_range(0, 65535));
      a16 = ra[15:0]; b16 = rb[15:0]; #1;
      e = ref_f(16, ra, rb);
      check("rnd16", {12'd0, c16, ov16, z16, n16, out16}, {12'd0, e});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
